// File: rtl/sw_regfile_arbiter.sv
// Zero-fill sequencer and round-robin arbiter for the 128-entry score register file.
// Define SW_ARB_GRANT_CNT_EN to add the gnt_cnt0/gnt_cnt1 grant counters.
module sw_regfile_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rf_w_en,
    output logic [31:0]           rf_r_addr,
    output logic [31:0]           rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    input  logic [DATA_WIDTH-1:0] rf_r_data
`ifdef SW_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1
`endif
);

    typedef enum logic {CLEAR, ARB} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  prio;
    logic                  rd0;
    logic                  rd1;
    logic                  arb_ok;
    logic                  acc;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign arb_ok = (state == ARB) && !rst;
    assign gnt0   = arb_ok && req0 && (!req1 || !prio);
    assign gnt1   = arb_ok && req1 && (!req0 || prio);
    assign acc    = gnt0 || gnt1;

    assign sel_we    = gnt1 ? we1 : we0;
    assign sel_addr  = gnt1 ? addr1 : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    assign busy      = (state == CLEAR);
    assign rdata     = rf_r_data;
    assign rf_r_addr = 32'(r_addr);
    assign rf_w_addr = 32'(w_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            clr_done  <= 1'b0;
            prio      <= 1'b0;
            rf_w_en   <= 1'b0;
            r_addr    <= '0;
            w_addr    <= '0;
            rf_w_data <= '0;
            rd0       <= 1'b0;
            rd1       <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            rd0      <= gnt0 && !we0;
            rd1      <= gnt1 && !we1;
            rvalid0  <= rd0;
            rvalid1  <= rd1;
            rf_w_en  <= 1'b0;
            clr_done <= 1'b0;
            if (acc) begin
                rf_w_en <= sel_we;
                if (sel_we) begin
                    w_addr    <= sel_addr;
                    rf_w_data <= sel_wdata;
                end else begin
                    r_addr <= sel_addr;
                end
            end
            if (arb_ok && req0 && req1)
                prio <= ~prio;
            unique case (state)
                CLEAR: begin
                    // The cycle showing the last clear write also leaves CLEAR
                    if (clr_done) begin
                        state <= ARB;
                    end else begin
                        rf_w_en   <= 1'b1;
                        w_addr    <= clr_cnt;
                        rf_w_data <= '0;
                        clr_cnt   <= clr_cnt + 1'b1;
                        clr_done  <= (clr_cnt == ADDR_WIDTH'(DEPTH - 1));
                    end
                end
                ARB: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

`ifdef SW_ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == ARB && clr_start)) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0)
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt1)
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_regfile_arbiter.sv
// Bench for sw_regfile_arbiter: directed scenarios plus random traffic
// checked every cycle against a cycle-indexed behavioural model.
module tb_sw_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic        req0, req1, we0, we1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [31:0] rdata;
    logic        rvalid0, rvalid1;
    logic        rf_w_en;
    logic [31:0] rf_r_addr, rf_w_addr, rf_w_data;
    logic [31:0] rf_r_data;
`ifdef SW_ARB_GRANT_CNT_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    sw_regfile_arbiter dut (
        .clk(clk), .rst(rst), .clr_start(clr_start),
        .busy(busy), .clr_done(clr_done),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rf_w_en(rf_w_en), .rf_r_addr(rf_r_addr),
        .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rf_r_data(rf_r_data)
`ifdef SW_ARB_GRANT_CNT_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    // Register file: registered read, write on the same edge
    logic [31:0] rf_mem [128];
    always @(posedge clk) begin
        rf_r_data <= rf_mem[rf_r_addr[6:0]];
        if (rf_w_en)
            rf_mem[rf_w_addr[6:0]] <= rf_w_data;
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    // Behavioural model. clear_pos counts cycles since entering CLEAR
    // (-1 = arbitrating); cycle k in 1..DEPTH shows clear write k-1.
    bit          armed = 0;
    int          cyc = 0;
    int          clear_pos;
    bit          prio;
    bit          cur_v, cur_we;
    int          cur_addr, cur_id;
    logic [31:0] cur_data;
    logic [31:0] mmem [128];
    int          m_raddr, m_waddr;
    logic [31:0] m_wdata;
    int          mc0, mc1;
    int          rq_due[$];
    int          rq_id[$];
    logic [31:0] rq_data[$];
    bit          m_arb, eg0, eg1, ev0, ev1, enter;
    logic [31:0] erd;

    always @(negedge clk) begin
        cyc++;
        m_arb = armed && clear_pos < 0 && !rst;
        eg0 = m_arb && req0 && (!req1 || !prio);
        eg1 = m_arb && req1 && (!req0 || prio);
        if (armed) begin
            if (clear_pos >= 1) begin
                cur_v = 1; cur_we = 1;
                cur_addr = clear_pos - 1;
                cur_data = 0;
            end
            if (cur_v && cur_we) begin
                m_waddr = cur_addr;
                m_wdata = cur_data;
            end
            if (cur_v && !cur_we)
                m_raddr = cur_addr;
            ev0 = 0; ev1 = 0; erd = 0;
            while (rq_due.size() > 0 && rq_due[0] == cyc) begin
                if (rq_id[0] == 0) ev0 = 1; else ev1 = 1;
                erd = rq_data[0];
                void'(rq_due.pop_front());
                void'(rq_id.pop_front());
                void'(rq_data.pop_front());
            end
            chk("busy", busy, 32'(clear_pos >= 0));
            chk("clr_done", clr_done, 32'(clear_pos == 128));
            chk("gnt0", gnt0, 32'(eg0));
            chk("gnt1", gnt1, 32'(eg1));
            chk("rf_w_en", rf_w_en, 32'(cur_v && cur_we));
            chk("rf_w_addr", rf_w_addr, m_waddr);
            chk("rf_r_addr", rf_r_addr, m_raddr);
            if (cur_v && cur_we)
                chk("rf_w_data", rf_w_data, cur_data);
            chk("rvalid0", rvalid0, 32'(ev0));
            chk("rvalid1", rvalid1, 32'(ev1));
            if (ev0 || ev1)
                chk("rdata", rdata, erd);
`ifdef SW_ARB_GRANT_CNT_EN
            chk("gnt_cnt0", gnt_cnt0, mc0);
            chk("gnt_cnt1", gnt_cnt1, mc1);
`endif
            if (cur_v && !cur_we) begin
                rq_due.push_back(cyc + 1);
                rq_id.push_back(cur_id);
                rq_data.push_back(mmem[cur_addr]);
            end
            if (cur_v && cur_we)
                mmem[cur_addr] = cur_data;
        end
        if (rst) begin
            armed = 1; clear_pos = 0; prio = 0;
            cur_v = 0; cur_we = 0; cur_addr = 0;
            cur_id = 0; cur_data = 0;
            m_raddr = 0; m_waddr = 0; m_wdata = 0;
            mc0 = 0; mc1 = 0;
            rq_due.delete(); rq_id.delete(); rq_data.delete();
        end else if (armed) begin
            enter = clear_pos < 0 && clr_start;
            cur_v = eg0 || eg1;
            cur_we = eg0 ? we0 : we1;
            cur_addr = eg0 ? int'(addr0) : int'(addr1);
            cur_data = eg0 ? wdata0 : wdata1;
            cur_id = eg0 ? 0 : 1;
            if (clear_pos == 128) clear_pos = -1;
            else if (clear_pos >= 0) clear_pos++;
            else if (clr_start) clear_pos = 0;
            if (m_arb && req0 && req1) prio = !prio;
            if (enter) begin
                mc0 = 0; mc1 = 0;
            end else begin
                if (eg0) mc0 = (mc0 + 1) % 65536;
                if (eg1) mc1 = (mc1 + 1) % 65536;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int id, input bit we,
                         input logic [6:0] a, input logic [31:0] d);
        bit done = 0;
        if (id == 0) begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = d;
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (id == 0) ? gnt0 : gnt1;
            step();
        end
        req0 = 0;
        req1 = 0;
        if (!done) chk("op_timeout", 0, 1);
    endtask

    task automatic read_check(input int id, input logic [6:0] a,
                              input logic [31:0] exp, input string nm);
        do_op(id, 0, a, 0);
        @(negedge clk);
        chk({nm, "_raddr"}, rf_r_addr, 32'(a));
        @(negedge clk);
        chk({nm, "_rvalid"}, id == 0 ? rvalid0 : rvalid1, 1);
        chk({nm, "_rdata"}, rdata, exp);
        step();
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 400) begin
            step();
            i++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int k, done_addr, bc, gc;
        bit g0, g1;
        rst = 1; clr_start = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_w_en", rf_w_en, 0);
        chk("rst_w_addr", rf_w_addr, 0);
        chk("rst_r_addr", rf_r_addr, 0);
        chk("rst_w_data", rf_w_data, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        k = 0; done_addr = -1;
        for (int i = 0; i < 300 && busy; i++) begin
            if (rf_w_en) begin
                chk("clr_addr", rf_w_addr, k);
                chk("clr_data", rf_w_data, 0);
                k++;
            end
            if (clr_done) done_addr = rf_w_addr;
            @(negedge clk);
        end
        chk("clear_writes", k, 128);
        chk("clr_done_addr", done_addr, 127);
        chk("busy_after_clear", busy, 0);
        step();

        read_check(1, 7'd5, 32'h0, "rd5");
        do_op(0, 1, 7'd10, 32'h0000ABCD);
        read_check(0, 7'd10, 32'h0000ABCD, "wr_rd10");

        req0 = 1; we0 = 0; addr0 = 7'd1;
        req1 = 1; we1 = 0; addr1 = 7'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_gnt0", gnt0, 32'(i % 2 == 0));
            chk("alt_gnt1", gnt1, 32'(i % 2 == 1));
            step();
        end
        req0 = 0; req1 = 0;
        repeat (3) step();

        do_op(0, 1, 7'd3, 32'h00001234);
        do_op(1, 0, 7'd3, 0);
        clr_start = 1;
        step();
        clr_start = 0;
        @(negedge clk);
        chk("inflight_rvalid", rvalid1, 1);
        chk("inflight_rdata", rdata, 32'h00001234);
        step();
        req1 = 1; we1 = 0; addr1 = 7'd3;
        @(negedge clk);
        bc = 0; gc = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            bc++;
            if (gnt0 || gnt1) gc++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", bc, 128);
        chk("gnt_in_clear", gc, 0);
        chk("gnt_after_clear", gnt1, 1);
        step();
        req1 = 0;
        @(negedge clk);
        chk("post_clr_raddr", rf_r_addr, 3);
        @(negedge clk);
        chk("post_clr_rvalid", rvalid1, 1);
        chk("post_clr_rdata", rdata, 0);
        step();

        do_op(0, 0, 7'd7, 0);
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_drop_rvalid", {rvalid1, rvalid0}, 0);
        chk("rst_busy2", busy, 1);
        step();
        @(negedge clk);
        chk("restart_w_en", rf_w_en, 1);
        chk("restart_w_addr", rf_w_addr, 0);
        step();
        wait_idle();

`ifdef SW_ARB_GRANT_CNT_EN
        for (int i = 0; i < 5; i++) do_op(0, 1, 7'(i), 32'(i));
        for (int i = 0; i < 3; i++) do_op(1, 0, 7'(i), 0);
        @(negedge clk);
        chk("cnt0_lit", gnt_cnt0, 5);
        chk("cnt1_lit", gnt_cnt1, 3);
        step();
        clr_start = 1;
        step();
        clr_start = 0;
        @(negedge clk);
        chk("cnt0_clr", gnt_cnt0, 0);
        chk("cnt1_clr", gnt_cnt1, 0);
        step();
        wait_idle();
`endif

        g0 = 0; g1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!req0 || g0) begin
                req0 = $urandom_range(0, 9) < 6;
                we0 = 1'($urandom_range(0, 1));
                addr0 = 7'($urandom_range(0, 15));
                wdata0 = $urandom;
            end
            if (!req1 || g1) begin
                req1 = $urandom_range(0, 9) < 6;
                we1 = 1'($urandom_range(0, 1));
                addr1 = 7'($urandom_range(0, 15));
                wdata1 = $urandom;
            end
            clr_start = $urandom_range(0, 299) == 0;
            rst = $urandom_range(0, 999) == 0;
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            step();
        end
        req0 = 0; req1 = 0; clr_start = 0; rst = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_regfile_arbiter.md
Name: sw_regfile_arbiter

Overview:
- Single-port arbiter and init sequencer for the 128-entry score register file, which has a registered read (1-cycle) and a write on the same clock edge.
- Shares the register file between two requesters: requester 0 is the PE-array score writeback; requester 1 is the host/traceback access.
- After reset, and on command, zero-fills all entries before granting any access.

Parameters:
- DATA_WIDTH, 32, width of a score word.
- ADDR_WIDTH, 7, requester address width.
- DEPTH, 128, number of entries cleared; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- clr_start  in  1  one-cycle pulse; requests a zero-fill.
- busy  out  1  high while clearing.
- clr_done  out  1  one-cycle pulse when the last clear write is issued.
- req0, req1  in  1  access request, held until granted.
- we0, we1  in  1  1 = write, 0 = read; valid with req.
- addr0, addr1  in  ADDR_WIDTH  entry address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- gnt0, gnt1  out  1  combinational accept; transfer occurs on the edge where req&gnt.
- rdata  out  DATA_WIDTH  read return, shared by both requesters.
- rvalid0, rvalid1  out  1  rdata valid for that requester.
- rf_w_en  out  1  to register file w_en.
- rf_r_addr, rf_w_addr  out  32  to register file; zero-extended from ADDR_WIDTH.
- rf_w_data  out  DATA_WIDTH  to register file w_data.
- rf_r_data  in  DATA_WIDTH  from register file r_data.

Behaviour:
- FSM states: CLEAR, ARB.
  - rst → CLEAR, clr_cnt=0.
  - CLEAR: each cycle issue write of 0 to clr_cnt, then clr_cnt++.
  - When clr_cnt==DEPTH-1 is issued: clr_done=1 that cycle, go to ARB next cycle.
  - ARB + clr_start → CLEAR, clr_cnt=0. clr_start is ignored while in CLEAR.
- busy=1 in CLEAR. gnt0=gnt1=0 in CLEAR and during rst.
- Arbitration in ARB:
  - Round-robin with priority pointer prio (reset 0).
  - Sole requester is granted.
  - If both request, the requester prio points to is granted; prio then toggles to the other.
  - prio is unchanged when nothing is granted.
  - Exactly one gnt at most per cycle.
- Issue stage (registered):
  - Accept at edge N drives rf_* during cycle N+1.
  - Write: rf_w_en=1, rf_w_addr=addr, rf_w_data=wdata.
  - Read: rf_w_en=0, rf_r_addr=addr.
  - Idle cycle: rf_w_en=0; rf_r_addr and rf_w_addr hold their last value.
- Read return:
  - Register file samples at edge N+1; rf_r_data is valid in cycle N+2.
  - rdata = rf_r_data, passed combinationally.
  - rvalid0/rvalid1 are a 2-stage registered pipeline of the accepted read's requester ID.
  - Read latency is 2 cycles from accept. Throughput is 1 op/cycle, back-to-back.
- Ordering: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data, because the write lands at N+1 and the read samples at N+2.
- clr_start while reads are in flight: the rvalid pipeline completes unaffected. Clear writes start the cycle after the last accepted op is issued.
- rst mid-operation: the rvalid pipeline, rf_w_en, gnt and clr_done are zeroed the next edge; in-flight reads are dropped.
- Reset values: gnt0/1=0, rvalid0/1=0, rf_w_en=0, rf_r_addr=rf_w_addr=0, rf_w_data=0, clr_done=0, busy=1.

Optional Feature:
- Macro SW_ARB_GRANT_CNT_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each.
  - Each counts accepted transfers for its requester and wraps at 0xFFFF→0.
  - Both are zeroed by rst and on entry to CLEAR.
- Undefined: no ports, no counters; all other behaviour is identical.

Test Plan:
- Reset, no requests:
  - busy=1 for 128 cycles with rf_w_en=1 and rf_w_addr 0..127, rf_w_data=0.
  - clr_done pulses with address 127; busy=0 the next cycle.
- After clear, req1 read at addr 5 → rf_r_addr=5 one cycle later; rvalid1=1 and rdata=0 two cycles after accept.
- req0 writes 0x0000ABCD to addr 10, then next cycle reads addr 10 → rvalid0=1 with rdata=0x0000ABCD, 2 cycles after the read accept.
- req0 and req1 held high for 6 cycles → grants alternate 0,1,0,1,0,1; never both high; rvalid is routed to the correct requester.
- clr_start while a read of addr 3 is in flight:
  - rvalid completes with the pre-clear data.
  - Then 128 clear writes, with gnt held 0 throughout.
  - A subsequent read returns 0.
- rst asserted one cycle after a read accept → no rvalid; the clear sequence restarts at addr 0.
- With SW_ARB_GRANT_CNT_EN: 5 grants to req0 and 3 to req1 → gnt_cnt0=5, gnt_cnt1=3; clr_start → both 0.
